// File: rtl/countdown_timer.sv
// Loadable down-counting timer: loads a start value, decrements once per tick, pulses done on expiry.
// Latency: count/busy update at the accepting edge; done rises N ticked cycles after a start of value N.
// No backpressure: start is only sampled in IDLE or DONE; abort overrides tick and start everywhere.
// Optional build macro COUNTDOWN_AUTO_RELOAD_EN: DONE reloads the last start value instead of idling.
module countdown_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] load_value,
   input  logic             tick,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic [WIDTH-1:0] count_dec;
   logic             load_acc;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload;
`endif

   // Decrement stage; only consumed in COUNT, where count is at least 1, so it never borrows.
   assign count_dec = count - WIDTH'(1);

   // Next-state and next-count decode; abort is checked first in every state.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      load_acc  = 1'b0;
      case (state)
         IDLE: begin
            if (!abort && start) begin
               load_acc  = 1'b1;
               count_nxt = load_value;
               state_nxt = (load_value != '0) ? COUNT : DONE;
            end
         end
         COUNT: begin
            if (abort) begin
               count_nxt = '0;
               state_nxt = IDLE;
            end else if (tick) begin
               count_nxt = count_dec;
               if (count == WIDTH'(1)) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (start) begin
               load_acc  = 1'b1;
               count_nxt = load_value;
               state_nxt = (load_value != '0) ? COUNT : DONE;
            end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
               // A zero reload keeps the block parked in DONE with done held high.
               if (reload != '0) begin
                  count_nxt = reload;
                  state_nxt = COUNT;
               end else begin
                  state_nxt = DONE;
               end
`else
               state_nxt = IDLE;
`endif
            end
         end
         default: begin
            count_nxt = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   // State, count and decoded outputs are all registered so nothing is combinational from inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         busy  <= (state_nxt == COUNT);
         done  <= (state_nxt == DONE);
      end
   end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   // Remember the most recently accepted start value for periodic reload.
   always_ff @(posedge clk) begin
      if (reset) begin
         reload <= '0;
      end else if (load_acc) begin
         reload <= load_value;
      end
   end
`endif

endmodule
